// File: rtl/fetch_predictor_pkg.sv
// Shared widths and 2-bit branch counter encodings for the IF-stage predictor.
package fetch_predictor_pkg;

  localparam int DEF_WORD_SIZE    = 16;
  localparam int DEF_BTB_IDX_BITS = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Saturating step toward taken or not-taken, clamped at 00 and 11.
  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      case (c)
        CTR_SNT: r = CTR_WNT;
        CTR_WNT: r = CTR_WT;
        default: r = CTR_ST;
      endcase
    end else begin
      case (c)
        CTR_ST:  r = CTR_WT;
        CTR_WT:  r = CTR_WNT;
        default: r = CTR_SNT;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_predictor_btb_table.sv
// Direct-mapped BTB: storage, combinational lookup port and EX-resolution update.
module fetch_predictor_btb_table
  import fetch_predictor_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int IDX_BITS  = DEF_BTB_IDX_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 lookup_hit,
  output logic                 lookup_taken,
  output logic [WORD_SIZE-1:0] lookup_target,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_is_jump
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  ctr_t                 ctr_q    [ENTRIES];
  logic                 jump_q   [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  ctr_t                lk_ctr;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;

  assign lk_idx = lookup_pc[IDX_BITS-1:0];
  assign lk_tag = lookup_pc[WORD_SIZE-1:IDX_BITS];
  assign lk_ctr = ctr_q[lk_idx];

  // Lookup reads registered contents only; a same-cycle update is not bypassed.
  assign lookup_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken  = jump_q[lk_idx] || (lk_ctr == CTR_WT) || (lk_ctr == CTR_ST);
  assign lookup_target = target_q[lk_idx];

  assign up_idx = upd_pc[IDX_BITS-1:0];
  assign up_tag = upd_pc[WORD_SIZE-1:IDX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
        jump_q[i]   <= 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        // Jumps bypass the counter via the jump bit, so only conditionals train it.
        if (!upd_is_jump) begin
          ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd_taken);
        end
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
        end
        jump_q[up_idx] <= upd_is_jump;
      end else if (upd_taken || upd_is_jump) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= upd_is_jump ? CTR_ST : CTR_WT;
        jump_q[up_idx]   <= upd_is_jump;
      end
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// IF-stage PC owner: BTB-based next-PC prediction with stall-aware miss redirect.
module fetch_predictor
  import fetch_predictor_pkg::*;
#(
  parameter int                       WORD_SIZE    = DEF_WORD_SIZE,
  parameter int                       BTB_IDX_BITS = DEF_BTB_IDX_BITS,
  parameter logic [WORD_SIZE-1:0]     RESET_PC     = '0,
  parameter bit                       PREDICT_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write,
  input  logic                 i_branch_miss,
  input  logic                 jump_miss,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_is_jump,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_next_pc,
  output logic                 redirect_pending
);

  logic                 btb_hit;
  logic                 btb_taken;
  logic [WORD_SIZE-1:0] btb_target;
  logic [WORD_SIZE-1:0] pending_pc;
  logic [WORD_SIZE-1:0] pc_plus_one;
  logic                 miss;

  fetch_predictor_btb_table #(
    .WORD_SIZE (WORD_SIZE),
    .IDX_BITS  (BTB_IDX_BITS)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (pc),
    .lookup_hit    (btb_hit),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .upd_is_jump   (upd_is_jump)
  );

  assign pc_plus_one  = pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  assign pred_taken   = PREDICT_EN && btb_hit && btb_taken;
  assign pred_next_pc = pred_taken ? btb_target : pc_plus_one;
  assign miss         = i_branch_miss || jump_miss;

  // A fresh miss always beats an older pending redirect; the newest target wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= RESET_PC;
      pending_pc       <= '0;
      redirect_pending <= 1'b0;
    end else if (miss) begin
      if (pc_write) begin
        pc               <= redirect_pc;
        redirect_pending <= 1'b0;
      end else begin
        pending_pc       <= redirect_pc;
        redirect_pending <= 1'b1;
      end
    end else if (pc_write) begin
      if (redirect_pending) begin
        pc               <= pending_pc;
        redirect_pending <= 1'b0;
      end else begin
        pc <= pred_next_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_predictor.sv
// Scoreboard bench for fetch_predictor: expectations queued with stimulus, checked after each edge.
module tb_fetch_predictor;

  localparam int SEL_PC    = 0;
  localparam int SEL_TAKEN = 1;
  localparam int SEL_NEXT  = 2;
  localparam int SEL_PEND  = 3;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        i_branch_miss;
  logic        jump_miss;
  logic [15:0] redirect_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;
  logic [15:0] pc;
  logic        pred_taken;
  logic [15:0] pred_next_pc;
  logic        redirect_pending;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  fetch_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .pc_write         (pc_write),
    .i_branch_miss    (i_branch_miss),
    .jump_miss        (jump_miss),
    .redirect_pc      (redirect_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_taken        (upd_taken),
    .upd_is_jump      (upd_is_jump),
    .pc               (pc),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_PC:    return pc;
      SEL_TAKEN: return {15'd0, pred_taken};
      SEL_NEXT:  return pred_next_pc;
      default:   return {15'd0, redirect_pending};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic idle();
    pc_write      = 1'b1;
    i_branch_miss = 1'b0;
    jump_miss     = 1'b0;
    redirect_pc   = 16'h0000;
    upd_valid     = 1'b0;
    upd_pc        = 16'h0000;
    upd_target    = 16'h0000;
    upd_taken     = 1'b0;
    upd_is_jump   = 1'b0;
  endtask

  task automatic upd(input logic [15:0] p, input logic [15:0] t, input logic tk, input logic j);
    upd_valid   = 1'b1;
    upd_pc      = p;
    upd_target  = t;
    upd_taken   = tk;
    upd_is_jump = j;
  endtask

  task automatic go_to(input logic [15:0] addr);
    pc_write    = 1'b1;
    jump_miss   = 1'b1;
    redirect_pc = addr;
    push("goto_pc", SEL_PC, addr);
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    push("rst_pc", SEL_PC, 16'h0000);
    push("rst_pend", SEL_PEND, 16'h0000);
    push("rst_taken", SEL_TAKEN, 16'h0000);
    push("rst_next", SEL_NEXT, 16'h0001);
    settle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push("free_run", SEL_PC, 16'h0001);
    tick();

    // Allocation of a taken conditional, landing on it the same edge
    upd(16'h0005, 16'h0040, 1'b1, 1'b0);
    push("alloc_taken", SEL_TAKEN, 16'h0001);
    push("alloc_next", SEL_NEXT, 16'h0040);
    go_to(16'h0005);

    // Counter training with pc held
    pc_write = 1'b0;
    upd(16'h0005, 16'h0099, 1'b0, 1'b0);
    push("no_bypass", SEL_NEXT, 16'h0040);
    settle();
    push("nt1_taken", SEL_TAKEN, 16'h0000);
    push("nt1_next", SEL_NEXT, 16'h0006);
    push("hold_pc", SEL_PC, 16'h0005);
    tick();
    push("nt2_taken", SEL_TAKEN, 16'h0000);
    tick();
    push("nt3_taken", SEL_TAKEN, 16'h0000);
    tick();
    upd(16'h0005, 16'h0044, 1'b1, 1'b0);
    push("sat_lo_t1", SEL_TAKEN, 16'h0000);
    tick();
    push("sat_lo_t2", SEL_TAKEN, 16'h0001);
    push("retarget", SEL_NEXT, 16'h0044);
    tick();
    tick();
    tick();
    upd(16'h0005, 16'h0044, 1'b0, 1'b0);
    push("sat_hi", SEL_TAKEN, 16'h0001);
    push("hold_pc2", SEL_PC, 16'h0005);
    tick();
    idle();

    // Aliasing: same index, different tag
    go_to(16'h0015);
    push("alias_taken", SEL_TAKEN, 16'h0000);
    push("alias_next", SEL_NEXT, 16'h0016);
    settle();

    // Not-taken miss must not allocate
    upd(16'h0030, 16'h0099, 1'b0, 1'b0);
    go_to(16'h0030);
    push("nt_noalloc", SEL_TAKEN, 16'h0000);
    settle();

    // Jump allocation, then follow the prediction
    upd(16'h0037, 16'h0200, 1'b1, 1'b1);
    go_to(16'h0037);
    push("jmp_taken", SEL_TAKEN, 16'h0001);
    push("jmp_next", SEL_NEXT, 16'h0200);
    settle();
    push("follow_pred", SEL_PC, 16'h0200);
    tick();

    // Stalled redirect
    pc_write    = 1'b0;
    jump_miss   = 1'b1;
    redirect_pc = 16'h0080;
    push("stall_pc", SEL_PC, 16'h0200);
    push("stall_pend", SEL_PEND, 16'h0001);
    tick();
    idle();
    pc_write = 1'b0;
    push("stall2_pc", SEL_PC, 16'h0200);
    push("stall2_pend", SEL_PEND, 16'h0001);
    tick();
    pc_write = 1'b1;
    push("release_pc", SEL_PC, 16'h0080);
    push("release_pend", SEL_PEND, 16'h0000);
    tick();

    // Newest pending redirect wins
    pc_write      = 1'b0;
    i_branch_miss = 1'b1;
    redirect_pc   = 16'h0100;
    tick();
    redirect_pc = 16'h0120;
    tick();
    idle();
    push("newest_pc", SEL_PC, 16'h0120);
    tick();

    // Fresh miss beats pending in the same cycle
    pc_write    = 1'b0;
    jump_miss   = 1'b1;
    redirect_pc = 16'h0300;
    tick();
    idle();
    i_branch_miss = 1'b1;
    redirect_pc   = 16'h0310;
    push("miss_vs_pend_pc", SEL_PC, 16'h0310);
    push("miss_vs_pend_p", SEL_PEND, 16'h0000);
    tick();
    idle();

    // Miss precedence over a predicted-taken BTB hit
    go_to(16'h0005);
    push("pre_miss_next", SEL_NEXT, 16'h0044);
    settle();
    i_branch_miss = 1'b1;
    redirect_pc   = 16'h0010;
    push("miss_prec", SEL_PC, 16'h0010);
    tick();
    idle();

    // Wrap at the top of the address space
    go_to(16'hFFFF);
    push("wrap_next", SEL_NEXT, 16'h0000);
    settle();
    push("wrap_pc", SEL_PC, 16'h0000);
    tick();

    // Asynchronous reset mid-run with a pending redirect
    go_to(16'h0023);
    pc_write    = 1'b0;
    jump_miss   = 1'b1;
    redirect_pc = 16'h0050;
    push("pre_rst_pend", SEL_PEND, 16'h0001);
    push("pre_rst_pc", SEL_PC, 16'h0023);
    tick();
    idle();
    #2;
    reset = 1'b1;
    push("arst_pc", SEL_PC, 16'h0000);
    push("arst_pend", SEL_PEND, 16'h0000);
    push("arst_next", SEL_NEXT, 16'h0001);
    push("arst_taken", SEL_TAKEN, 16'h0000);
    settle();
    push("arst_hold", SEL_PC, 16'h0000);
    tick();
    reset = 1'b0;
    go_to(16'h0005);
    push("btb_cleared", SEL_TAKEN, 16'h0000);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_predictor.md
Name: fetch_predictor

Overview:
- IF-stage PC owner, sits directly upstream of the hazard control unit.
- Holds the program counter and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives the fetch address and the predicted next PC into IF/ID.
- Consumes pc_write and the branch/jump miss redirects produced around the hazard control unit, plus EX-stage resolution updates.

Parameters:
- WORD_SIZE, 16, PC and target width in bits.
- BTB_IDX_BITS, 4, log2 of BTB entries (16 entries).
- RESET_PC, 16'h0000, PC value after reset.
- PREDICT_EN, 1, 0 forces the prediction to PC+1 (BTB still updates).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_write  in  1  from hazard unit; 0 means hold the PC.
- i_branch_miss  in  1  conditional branch mispredicted, resolved in EX.
- jump_miss  in  1  unconditional jump mispredicted.
- redirect_pc  in  WORD_SIZE  correct next PC when either miss is asserted.
- upd_valid  in  1  EX resolved a branch or jump this cycle.
- upd_pc  in  WORD_SIZE  PC of the resolved instruction.
- upd_target  in  WORD_SIZE  resolved target.
- upd_taken  in  1  resolved direction; always 1 for jumps.
- upd_is_jump  in  1  resolved instruction is JMP/JAL/JPR/JRL.
- pc  out  WORD_SIZE  current fetch address, registered.
- pred_taken  out  1  BTB predicts taken for pc; combinational.
- pred_next_pc  out  WORD_SIZE  predicted next fetch address; combinational; piped down for miss detection.
- redirect_pending  out  1  a redirect is latched and waiting for pc_write.

Behaviour:
- Reset (async): pc = RESET_PC; all BTB valid bits = 0; counters = 2'b01; jump bits = 0; redirect_pending = 0. Combinational outputs follow from that state.
- Lookup (combinational on pc):
  - idx = pc[BTB_IDX_BITS-1:0]; tag = pc[WORD_SIZE-1:BTB_IDX_BITS].
  - hit = valid[idx] && tag match.
  - pred_taken = PREDICT_EN && hit && (jump[idx] || ctr[idx][1]).
  - pred_next_pc = pred_taken ? target[idx] : pc+1, wrapping modulo 2^WORD_SIZE (16'hFFFF+1 = 16'h0000).
- Next-PC priority, evaluated each rising edge:
  1. Miss (i_branch_miss || jump_miss) with pc_write=1: pc <= redirect_pc.
  2. Miss with pc_write=0: latch redirect_pc into the pending register; set redirect_pending; pc holds.
  3. redirect_pending=1 and pc_write=1: pc <= pending target; clear pending.
  4. pc_write=0: pc holds.
  5. Otherwise: pc <= pred_next_pc.
- A new miss arriving while a redirect is pending overwrites the pending target. The newest redirect wins.
- Miss and pending clear in the same cycle with pc_write=1: redirect_pc wins; pending clears.
- Latency: a redirect is visible on pc one cycle after the miss edge, given pc_write=1.
- BTB update (synchronous, on upd_valid; independent of pc_write, stall and miss):
  - Entry hit (valid, tag equal):
    - Conditional: counter saturating +1 if taken, -1 if not (bounds 00..11).
    - target <= upd_target if taken.
    - jump <= upd_is_jump.
  - Entry miss and (upd_taken || upd_is_jump): allocate.
    - valid = 1, tag written, target = upd_target.
    - ctr = upd_is_jump ? 11 : 10.
    - jump = upd_is_jump.
  - Entry miss and not taken: no write.
- Update and lookup to the same index in the same cycle: lookup sees the old contents; no bypass.
- Reset mid-operation clears everything, including a pending redirect.

Decomposition:
- Shared constants (WORD_SIZE, counter encodings SNT=00/WNT=01/WT=10/ST=11) go in constants.v.
- One sub-module: btb_table, holding the storage plus the lookup port and the update/saturation logic.
- PC and redirect sequencing stay in fetch_predictor.

Test Plan:
- Reset mid-run: assert reset asynchronously with pc=16'h0023 and a redirect pending -> pc=16'h0000 immediately, redirect_pending=0, pred_next_pc=16'h0001.
- Allocation: upd_valid, upd_pc=16'h0005, upd_target=16'h0040, upd_taken=1, upd_is_jump=0 -> at pc=16'h0005: pred_taken=1, pred_next_pc=16'h0040.
- Saturation: from the previous state, 3 not-taken updates at 16'h0005 -> ctr steps 10→01→00→00; after the first update pred_next_pc=16'h0006.
- Aliasing: entry tagged for 16'h0005; pc=16'h0015 (same idx, different tag) -> pred_taken=0, pred_next_pc=16'h0016.
- Stalled redirect: pc_write=0 while jump_miss=1 with redirect_pc=16'h0080 -> pc holds and redirect_pending=1. Next cycle pc_write=1 -> pc=16'h0080, pending=0.
- Miss precedence and wrap: i_branch_miss with redirect_pc=16'h0010 while the BTB predicts 16'h0040 -> pc=16'h0010. Separately, pc=16'hFFFF with no hit -> next pc=16'h0000.
